cmp_arbiter: RTL and testbench

// - Shares the single branch comparator (cmp) between two requesters: port 0 (branch resolution)
//   and port 1 (slt/sltu/compare path).
// - Round-robin arbitration, operand latching and comparator sequencing.
// - Per-port valid/ready handshake on both the request and the response side.
// - Sits between the control unit and the comparator; drives cmp's cmpop/rs1_out/cmp_mux_out
//   and samples br_en.

---
 rtl/cmp_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_cmp_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin sharing of the branch comparator between two
// requesters (port 0 branch resolution, port 1 slt/sltu/compare path).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/ready         request handshake, N = 0,1
//   reqN_op/a/b/tag          compare op, operands, opaque tag
//   rspN_valid/ready         response handshake
//   rspN_br_en/tag           compare result and returned tag
//   cmp_op/a/b               operands presented to the comparator
//   cmp_br_en                comparator result
//   grant_cnt0/1             saturating grant counters
//
// Optional feature macro: CMP_ARB_STATS_EN adds STAT_W and grant_cnt0/1.

module cmp_arbiter #(
    parameter int TAG_W = 4
`ifdef CMP_ARB_STATS_EN
    , parameter int STAT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp0_br_en,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic             rsp1_br_en,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic [2:0]       cmp_op,
    output logic [31:0]      cmp_a,
    output logic [31:0]      cmp_b,
    input  logic             cmp_br_en
`ifdef CMP_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] grant_cnt0,
    output logic [STAT_W-1:0] grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        RESP
    } state_t;

    state_t           state_q;
    logic             rr_q;
    logic             port_q;
    logic             res_q;
    logic             rsp0_v_q;
    logic             rsp1_v_q;
    logic [2:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [TAG_W-1:0] tag_q;

    logic gnt0;
    logic gnt1;
    logic rsp_hs;
    logic op_illegal;

    // Port 0 wins when alone or when both request and rr_q points at it.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && (!req1_valid || !rr_q)) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign rsp_hs = (rsp0_v_q && rsp0_ready)
                 || (rsp1_v_q && rsp1_ready);

    // funct3 010/011 have no branch meaning.
    assign op_illegal = (op_q[2:1] == 2'b01);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            port_q   <= 1'b0;
            res_q    <= 1'b0;
            rsp0_v_q <= 1'b0;
            rsp1_v_q <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        op_q    <= gnt1 ? req1_op  : req0_op;
                        a_q     <= gnt1 ? req1_a   : req0_a;
                        b_q     <= gnt1 ? req1_b   : req0_b;
                        tag_q   <= gnt1 ? req1_tag : req0_tag;
                        port_q  <= gnt1;
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    res_q    <= op_illegal ? 1'b0 : cmp_br_en;
                    rsp0_v_q <= !port_q;
                    rsp1_v_q <= port_q;
                    state_q  <= RESP;
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp0_v_q <= 1'b0;
                        rsp1_v_q <= 1'b0;
                        rr_q     <= ~port_q;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmp_op     = op_q;
    assign cmp_a      = a_q;
    assign cmp_b      = b_q;
    assign rsp0_valid = rsp0_v_q;
    assign rsp1_valid = rsp1_v_q;
    assign rsp0_br_en = res_q;
    assign rsp1_br_en = res_q;
    assign rsp0_tag   = tag_q;
    assign rsp1_tag   = tag_q;

`ifdef CMP_ARB_STATS_EN
    logic [STAT_W-1:0] cnt0_q;
    logic [STAT_W-1:0] cnt1_q;
    logic [STAT_W-1:0] cnt0_d;
    logic [STAT_W-1:0] cnt1_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (gnt0 && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
        if (gnt1 && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed checks of cmp_arbiter with a behavioural
// comparator model standing in for cmp.

module tb_cmp_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0;
    logic [31:0] req1_a = '0, req1_b = '0;
    logic [3:0]  req0_tag = '0, req1_tag = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic        rsp0_br_en, rsp1_br_en;
    logic [3:0]  rsp0_tag, rsp1_tag;
    logic [2:0]  cmp_op;
    logic [31:0] cmp_a, cmp_b;
    logic        cmp_br_en;
`ifdef CMP_ARB_STATS_EN
    logic [1:0]  grant_cnt0, grant_cnt1;
`endif

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cmp_arbiter #(
        .TAG_W(4)
`ifdef CMP_ARB_STATS_EN
        , .STAT_W(2)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_a(req0_a),
        .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_a(req1_a),
        .req1_b(req1_b), .req1_tag(req1_tag),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_br_en(rsp0_br_en), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_br_en(rsp1_br_en), .rsp1_tag(rsp1_tag),
        .cmp_op(cmp_op), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_br_en(cmp_br_en)
`ifdef CMP_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    // Comparator model; answers 1 on illegal ops so the arbiter's
    // forcing of those results to 0 is observable.
    always_comb begin
        cmp_br_en = 1'b1;
        case (cmp_op)
            3'b000: cmp_br_en = (cmp_a == cmp_b);
            3'b001: cmp_br_en = (cmp_a != cmp_b);
            3'b100: cmp_br_en = ($signed(cmp_a) < $signed(cmp_b));
            3'b101: cmp_br_en = ($signed(cmp_a) >= $signed(cmp_b));
            3'b110: cmp_br_en = (cmp_a < cmp_b);
            3'b111: cmp_br_en = (cmp_a >= cmp_b);
            default: cmp_br_en = 1'b1;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // One lone request on port p, rsp_ready held high, full latency checks.
    task automatic run_req(input int p, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag, input logic exp);
        nxt();
        if (p == 0) begin
            req0_valid = 1'b1; req0_op = op;
            req0_a = a; req0_b = b; req0_tag = tag;
        end else begin
            req1_valid = 1'b1; req1_op = op;
            req1_a = a; req1_b = b; req1_tag = tag;
        end
        @(negedge clk);
        check("run_rdy", (p == 0) ? req0_ready : req1_ready, 1);
        nxt();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("run_cmp_v", {rsp1_valid, rsp0_valid}, 0);
        nxt();
        @(negedge clk);
        check("run_v", {rsp1_valid, rsp0_valid}, (p == 0) ? 1 : 2);
        check("run_br", (p == 0) ? rsp0_br_en : rsp1_br_en, exp);
        check("run_tag", (p == 0) ? rsp0_tag : rsp1_tag, tag);
        nxt();
        @(negedge clk);
        check("run_done", {rsp1_valid, rsp0_valid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_v0", rsp0_valid, 0);
        check("rst_v1", rsp1_valid, 0);
        check("rst_op", cmp_op, 0);
        check("rst_a", cmp_a, 0);
        check("rst_tag", rsp0_tag, 0);
        nxt();
        rst = 1'b0;

        // Lone signed request, step by step
        nxt();
        req0_valid = 1'b1; req0_op = 3'b100;
        req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_tag = 4'd3;
        @(negedge clk);
        check("lone_rdy0", req0_ready, 1);
        check("lone_rdy1", req1_ready, 0);
        nxt();
        req0_valid = 1'b0;
        @(negedge clk);
        check("lone_cmp_v", rsp0_valid, 0);
        check("lone_op", cmp_op, 3'b100);
        check("lone_a", cmp_a, 32'hFFFF_FFFF);
        check("lone_b", cmp_b, 1);
        nxt();
        @(negedge clk);
        check("lone_v0", rsp0_valid, 1);
        check("lone_br", rsp0_br_en, 1);
        check("lone_tag", rsp0_tag, 3);
        check("lone_v1", rsp1_valid, 0);
        nxt();
        @(negedge clk);
        check("lone_drop", rsp0_valid, 0);

        // Unsigned compare on port 1
        run_req(1, 3'b110, 32'hFFFF_FFFF, 32'd1, 4'd5, 1'b0);

        // Contention from reset: grants 0,1,0
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b000;
        req0_a = 1; req0_b = 1; req0_tag = 4'd1;
        req1_valid = 1'b1; req1_op = 3'b001;
        req1_a = 1; req1_b = 1; req1_tag = 4'd2;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("ct_rdy0", req0_ready, (i == 0 || i == 6));
            check("ct_rdy1", req1_ready, (i == 3));
            if (i == 2) begin
                check("ct_v_a", {rsp1_valid, rsp0_valid}, 1);
                check("ct_br_a", rsp0_br_en, 1);
                check("ct_tag_a", rsp0_tag, 1);
            end
            if (i == 5) begin
                check("ct_v_b", {rsp1_valid, rsp0_valid}, 2);
                check("ct_br_b", rsp1_br_en, 0);
                check("ct_tag_b", rsp1_tag, 2);
            end
            nxt();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        nxt();
        @(negedge clk);
        check("ct_v_c", {rsp1_valid, rsp0_valid}, 1);
        check("ct_tag_c", rsp0_tag, 1);
        nxt();

        // Backpressure on port 0 while port 1 waits
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b101;
        req0_a = 5; req0_b = 5; req0_tag = 4'd9;
        @(negedge clk);
        check("bp_rdy0", req0_ready, 1);
        nxt();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 3'b000;
        req1_a = 0; req1_b = 0; req1_tag = 4'd4;
        @(negedge clk);
        check("bp_cmp_rdy1", req1_ready, 0);
        nxt();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_v0", rsp0_valid, 1);
            check("bp_br", rsp0_br_en, 1);
            check("bp_tag", rsp0_tag, 9);
            check("bp_rdy1", req1_ready, 0);
            nxt();
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_v0", rsp0_valid, 1);
        nxt();
        @(negedge clk);
        check("bp_idle_v0", rsp0_valid, 0);
        check("bp_idle_rdy1", req1_ready, 1);
        nxt();
        req1_valid = 1'b0;
        @(negedge clk);
        nxt();
        @(negedge clk);
        check("bp_v1", rsp1_valid, 1);
        check("bp_br1", rsp1_br_en, 1);
        check("bp_tag1", rsp1_tag, 4);
        nxt();

        // Reset during CMP
        req0_valid = 1'b1; req0_op = 3'b000;
        req0_a = 7; req0_b = 8; req0_tag = 4'd6;
        @(negedge clk);
        check("rm_rdy0", req0_ready, 1);
        nxt();
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rm_v", {rsp1_valid, rsp0_valid}, 0);
        check("rm_op", cmp_op, 0);
        nxt();
        @(negedge clk);
        check("rm_hold_v", {rsp1_valid, rsp0_valid}, 0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        check("rm_after_v", {rsp1_valid, rsp0_valid}, 0);
        run_req(0, 3'b000, 32'd7, 32'd7, 4'd2, 1'b1);

        // Illegal op forced to 0
        run_req(1, 3'b010, 32'd0, 32'd0, 4'd7, 1'b0);
        run_req(0, 3'b011, 32'd3, 32'd3, 4'd8, 1'b0);

`ifdef CMP_ARB_STATS_EN
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_req(1, 3'b111, 32'd2, 32'd1, 4'(i), 1'b1);
        end
        @(negedge clk);
        check("st_cnt1", grant_cnt1, 3);
        check("st_cnt0", grant_cnt0, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
